// File: rtl/ro_cal_pkg.sv
// Ring-oscillator calibration: shared types and constants.
// Sweep states, select width and select range.
package ro_cal_pkg;

  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] SEL_MAX = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_COMPARE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchroniser for the ring-oscillator clock,
// followed by a single-cycle rising-edge pulse.
module ro_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/ro_cal_ctrl.sv
// Sweeps the ring-oscillator select 0..15, counts edges per window
// and keeps the select whose count is closest to the target.
module ro_cal_ctrl
  import ro_cal_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 fpga_clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] target_cnt_i,
  input  logic                 ro_clk_i,
  output logic                 ro_enable_o,
  output logic [SEL_W-1:0]     freq_sel_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [SEL_W-1:0]     best_sel_o,
  output logic [CNT_WIDTH-1:0] best_err_o,
  output logic [CNT_WIDTH-1:0] meas_cnt_o
);

  localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ?
                           WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SET_LAST =
    TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_LAST =
    TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONES = '1;

  state_t               r_state;
  state_t               w_next;
  logic [TMR_W-1:0]     r_tmr;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_target;
  logic [SEL_W-1:0]     r_sel;
  logic [SEL_W-1:0]     r_wb_sel;
  logic [CNT_WIDTH-1:0] r_wb_err;
  logic [SEL_W-1:0]     r_best_sel;
  logic [CNT_WIDTH-1:0] r_best_err;
  logic [CNT_WIDTH-1:0] r_meas;
  logic                 r_en;

  logic                 w_rise;
  logic                 w_meas_entry;
  logic [CNT_WIDTH-1:0] w_err;
  logic                 w_better;
  logic [SEL_W-1:0]     w_new_sel;
  logic [CNT_WIDTH-1:0] w_new_err;

  ro_edge_sync u_sync (
    .i_clk   (fpga_clk_i),
    .i_rst   (reset_i),
    .i_async (ro_clk_i),
    .o_rise  (w_rise)
  );

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) w_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_tmr == SET_LAST) w_next = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (r_tmr == WIN_LAST) w_next = ST_COMPARE;
      end
      ST_COMPARE: begin
        w_next = (r_sel == SEL_MAX) ? ST_DONE : ST_SETTLE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Timer restarts on every state change so each phase is timed alone
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      r_tmr <= '0;
    end else if (w_next != r_state) begin
      r_tmr <= '0;
    end else if (r_state == ST_SETTLE ||
                 r_state == ST_MEASURE) begin
      r_tmr <= r_tmr + TMR_W'(1);
    end
  end

  assign w_meas_entry = (r_state == ST_SETTLE) &&
                        (w_next == ST_MEASURE);

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else if (w_meas_entry) begin
      r_cnt <= '0;
    end else if (r_state == ST_MEASURE && w_rise &&
                 r_cnt != CNT_ONES) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign w_err = (r_cnt >= r_target) ? (r_cnt - r_target)
                                     : (r_target - r_cnt);
  assign w_better  = (w_err < r_wb_err);
  assign w_new_sel = w_better ? r_sel : r_wb_sel;
  assign w_new_err = w_better ? w_err : r_wb_err;

  // Working best resets at accept; published best only moves in COMPARE
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      r_en       <= 1'b0;
      r_target   <= '0;
      r_sel      <= '0;
      r_wb_sel   <= '0;
      r_wb_err   <= '0;
      r_best_sel <= '0;
      r_best_err <= '0;
      r_meas     <= '0;
    end else begin
      r_en <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_target <= target_cnt_i;
            r_sel    <= '0;
            r_wb_sel <= '0;
            r_wb_err <= CNT_ONES;
          end
        end
        ST_COMPARE: begin
          r_meas     <= r_cnt;
          r_wb_sel   <= w_new_sel;
          r_wb_err   <= w_new_err;
          r_best_sel <= w_new_sel;
          r_best_err <= w_new_err;
          if (r_sel != SEL_MAX) r_sel <= r_sel + SEL_W'(1);
        end
        ST_DONE: begin
          r_sel <= r_best_sel;
        end
        default: begin
        end
      endcase
    end
  end

  assign ro_enable_o = r_en;
  assign freq_sel_o  = (r_state == ST_DONE) ? r_best_sel : r_sel;
  assign busy_o      = (r_state == ST_SETTLE)  ||
                       (r_state == ST_MEASURE) ||
                       (r_state == ST_COMPARE);
  assign done_o      = (r_state == ST_DONE);
  assign best_sel_o  = r_best_sel;
  assign best_err_o  = r_best_err;
  assign meas_cnt_o  = r_meas;

endmodule

// File: tb/tb_ro_cal_ctrl.sv
// Bench for ro_cal_ctrl: scripted and random sweeps against a
// queue-based scoreboard fed by a sweep-level reference model.
module tb_ro_cal_ctrl;

  localparam int W    = 100;
  localparam int S    = 4;
  localparam int CW   = 16;
  localparam int STEP = S + W + 1;
  localparam int LAT  = 16 * STEP + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] target;
  logic          ro;
  logic          ro_en;
  logic [3:0]    freq_sel;
  logic          busy;
  logic          done;
  logic [3:0]    best_sel;
  logic [CW-1:0] best_err;
  logic [CW-1:0] meas_cnt;

  ro_cal_ctrl #(
    .WINDOW_CYCLES (W),
    .SETTLE_CYCLES (S),
    .CNT_WIDTH     (CW)
  ) dut (
    .fpga_clk_i   (clk),
    .reset_i      (rst),
    .start_i      (start),
    .target_cnt_i (target),
    .ro_clk_i     (ro),
    .ro_enable_o  (ro_en),
    .freq_sel_o   (freq_sel),
    .busy_o       (busy),
    .done_o       (done),
    .best_sel_o   (best_sel),
    .best_err_o   (best_err),
    .meas_cnt_o   (meas_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    int          err;
    int          lo;
    int          hi;
    int unsigned dcyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          vec    = 0;
  int          bad    = 0;
  int          n_done = 0;
  int unsigned cyc    = 0;

  // RO model: 0 stuck low, 1 period sel+2, 2 scripted burst counts
  int          mode = 0;
  int unsigned acc  = 0;
  int          cnts[16];
  int          ph   = 0;
  logic [3:0]  last_sel = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act,
                     input longint req);
    vec++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  initial begin
    int rel;
    int k;
    int off;
    ro = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 1) begin
        if (freq_sel != last_sel) ph = 0;
        last_sel = freq_sel;
        ro = (ph == 0);
        ph = (ph + 1) % (int'(freq_sel) + 2);
      end else if (mode == 2 && cyc >= acc) begin
        rel = int'(cyc - acc);
        k   = rel / STEP;
        off = rel % STEP;
        ro  = (k < 16) && (off >= S + 10) &&
              (off < S + 10 + 2 * cnts[k]) &&
              ((off - S - 10) % 2 == 0);
      end else begin
        ro = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        vec++;
        bad++;
        $display("FAIL unexpected_done: done_o=1 at cycle %0d, required 0",
                 cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.dcyc);
        chk("best_sel", best_sel, e.sel);
        chk("best_err", best_err, e.err);
        chk("freq_sel_at_done", freq_sel, e.sel);
        vec++;
        if (int'(meas_cnt) < e.lo || int'(meas_cnt) > e.hi) begin
          bad++;
          $display("FAIL meas_cnt: got %0d required %0d..%0d",
                   meas_cnt, e.lo, e.hi);
        end
      end
    end
  end

  function automatic void model(input int t, output int bs,
                                output int be);
    int d;
    be = 65535;
    bs = 0;
    for (int k = 0; k < 16; k++) begin
      d = (cnts[k] > t) ? cnts[k] - t : t - cnts[k];
      if (d < be) begin
        be = d;
        bs = k;
      end
    end
  endfunction

  task automatic push_exp(input int sel, input int err, input int lo,
                          input int hi, input int unsigned a);
    exp_t x;
    x.sel  = sel;
    x.err  = err;
    x.lo   = lo;
    x.hi   = hi;
    x.dcyc = a + LAT - 1;
    sb.push_back(x);
  endtask

  task automatic start_at_negedge(input int t);
    target = CW'(t);
    start  = 1'b1;
    acc    = cyc + 1;
  endtask

  task automatic wait_done();
    int n0;
    int i;
    n0 = n_done;
    for (i = 0; i < LAT + 200; i++) begin
      @(negedge clk);
      #1;
      if (n_done > n0) break;
    end
    if (n_done <= n0) begin
      vec++;
      bad++;
      $display("FAIL done_timeout: no done_o within %0d cycles", i);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_freq_sel"}, freq_sel, 0);
    chk({tag, "_best_sel"}, best_sel, 0);
    chk({tag, "_best_err"}, best_err, 0);
    chk({tag, "_meas_cnt"}, meas_cnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ro_en"}, ro_en, 0);
  endtask

  task automatic burst_sweep(input int t);
    int bs;
    int be;
    model(t, bs, be);
    @(negedge clk);
    mode = 2;
    start_at_negedge(t);
    push_exp(bs, be, cnts[15], cnts[15], acc);
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    int bs;
    int be;
    int tb_t;
    int unsigned a0;
    rst    = 1'b1;
    start  = 1'b0;
    target = '0;
    for (int k = 0; k < 16; k++) cnts[k] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ro_en_after_reset", ro_en, 1);

    // Period sel+2: 100/5 gives an exact match at select 3
    mode = 1;
    start_at_negedge(20);
    push_exp(3, 0, W / 17, (W + 16) / 17, acc);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("idle_hold_freq_sel", freq_sel, 3);
    chk("idle_busy", busy, 0);

    // Equal errors at selects 4 and 5: the lower one wins
    for (int k = 0; k < 16; k++) cnts[k] = 0;
    cnts[4] = 30;
    cnts[5] = 26;
    burst_sweep(28);

    @(negedge clk);
    mode = 0;
    start_at_negedge(50);
    push_exp(0, 50, 0, 0, acc);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Stray starts inside a running sweep must not restart it
    for (int k = 0; k < 16; k++) cnts[k] = $urandom_range(40, 0);
    tb_t = $urandom_range(45, 0);
    model(tb_t, bs, be);
    @(negedge clk);
    mode = 2;
    start_at_negedge(tb_t);
    push_exp(bs, be, cnts[15], cnts[15], acc);
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 2) @(negedge clk);
    start  = 1'b1;
    target = CW'($urandom_range(45, 0));
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 50) @(negedge clk);
    chk("busy_in_measure", busy, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 3 * STEP + 60) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 16; k++) cnts[k] = $urandom_range(40, 0);
      burst_sweep($urandom_range(45, 0));
    end

    // start held through DONE: the next sweep begins straight after
    for (int k = 0; k < 16; k++) cnts[k] = $urandom_range(40, 0);
    tb_t = $urandom_range(45, 0);
    model(tb_t, bs, be);
    @(negedge clk);
    mode = 2;
    start_at_negedge(tb_t);
    a0 = acc;
    push_exp(bs, be, cnts[15], cnts[15], acc);
    @(negedge clk);
    tb_t = $urandom_range(45, 0);
    target = CW'(tb_t);
    wait_done();
    model(tb_t, bs, be);
    acc = a0 + LAT + 1;
    push_exp(bs, be, cnts[15], cnts[15], acc);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Abort at select 7, then a clean sweep
    @(negedge clk);
    mode = 1;
    start_at_negedge(20);
    push_exp(3, 0, W / 17, (W + 16) / 17, acc);
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 7 * STEP + 50) @(negedge clk);
    chk("sel_before_abort", freq_sel, 7);
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    check_zero("abort");
    rst = 1'b0;
    @(negedge clk);
    start_at_negedge(20);
    push_exp(3, 0, W / 17, (W + 16) / 17, acc);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
